// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver front end (8 data bits LSB first, even parity, 1 stop bit, 16x oversampling)
// Ports:
//   clk      - system clock, all logic on the rising edge
//   reset    - synchronous active-high reset
//   Rx_EN    - receiver enable; low holds the block idle and aborts any frame in progress
//   RxD      - asynchronous serial input, idles high
//   data_out - last completed byte, updated on every completed frame (errored or not)
//   valid    - one-cycle pulse: frame received with no errors
//   PERROR   - one-cycle pulse: parity mismatch
//   FERROR   - one-cycle pulse: stop bit sampled low
module uart_rx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       PERROR,
    output logic       FERROR
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tick_cnt, tick_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          perr, perr_n;
    logic          armed, armed_n;
    logic [7:0]    data_out_n;
    logic          valid_n, perror_n, ferror_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RxD;
            rx_s <= rx_m;
        end
    end

    assign tick = Rx_EN && (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || !Rx_EN)
            div_cnt <= '0;
        else
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            perr     <= 1'b0;
            armed    <= 1'b1;
            data_out <= '0;
            valid    <= 1'b0;
            PERROR   <= 1'b0;
            FERROR   <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            perr     <= perr_n;
            armed    <= armed_n;
            data_out <= data_out_n;
            valid    <= valid_n;
            PERROR   <= perror_n;
            FERROR   <= ferror_n;
        end
    end

    // armed blocks a new start after a low stop bit until the line has been seen high,
    // so a held-low line (break) yields one frame rather than a stream of them.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        perr_n     = perr;
        armed_n    = armed | rx_s;
        data_out_n = data_out;
        valid_n    = 1'b0;
        perror_n   = 1'b0;
        ferror_n   = 1'b0;
        if (!Rx_EN) begin
            state_n    = IDLE;
            tick_cnt_n = '0;
            bit_idx_n  = '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end
                START: begin
                    if (tick_cnt == 4'd7) begin
                        state_n    = rx_s ? IDLE : DATA;
                        tick_cnt_n = '0;
                        bit_idx_n  = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tick_cnt == 4'd15) begin
                        shift_n[bit_idx] = rx_s;
                        bit_idx_n        = bit_idx + 3'd1;
                        tick_cnt_n       = '0;
                        state_n          = (bit_idx == 3'd7) ? PARITY : DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    if (tick_cnt == 4'd15) begin
                        perr_n     = (^shift) ^ rx_s;
                        tick_cnt_n = '0;
                        state_n    = STOP;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (tick_cnt == 4'd15) begin
                        data_out_n = shift;
                        valid_n    = ~perr & rx_s;
                        perror_n   = perr;
                        ferror_n   = ~rx_s;
                        armed_n    = rx_s;
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: self-checking bench for uart_rx_frame (DIV=10, 160 clk per bit)
module tb_uart_rx_frame;
    localparam int BIT = 160;
    localparam int LAT_MIN = 1680;
    localparam int LAT_MAX = 1695;

    logic       clk = 1'b0, reset = 1'b1, Rx_EN = 1'b0, RxD = 1'b1;
    logic [7:0] data_out;
    logic       valid, PERROR, FERROR;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        int          cyc;
        logic [10:0] f;
    } ev_t;
    ev_t evq[$];

    uart_rx_frame #(.CLK_FREQ(1600000), .BAUD_RATE(10000), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .RxD(RxD),
        .data_out(data_out), .valid(valid), .PERROR(PERROR), .FERROR(FERROR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (valid || PERROR || FERROR) evq.push_back('{cyc, {valid, PERROR, FERROR, data_out}});

    // Expected {valid, PERROR, FERROR, data}: even parity over data+parity, stop must be high.
    function automatic logic [10:0] model(input logic [7:0] d, input logic p, input logic s);
        logic pe;
        pe = ^{d, p};
        return {~pe & s, pe, ~s, d};
    endfunction

    // Called at a negedge; leaves RxD at the stop bit level on return.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, output int e);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        e = cyc;
        for (int i = 0; i < 11; i++) begin
            RxD = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1;
        repeat (40) @(negedge clk);
        n_vec++;
        if ({valid, PERROR, FERROR, data_out} !== 11'h000) begin
            n_err++; $display("FAIL reset_outputs got %h want 000", {valid, PERROR, FERROR, data_out});
        end
        reset = 1'b0;
        evq.delete();
        repeat (2000) @(negedge clk);
        n_vec++;
        if (evq.size() != 0) begin
            n_err++; $display("FAIL idle_pulses got %0d want 0", evq.size());
        end
    endtask

    task automatic test_directed();
        logic [7:0] d[3] = '{8'hE3, 8'h4D, 8'hFF};
        logic       p[3] = '{1'b1, 1'b1, 1'b0};
        logic       s[3] = '{1'b1, 1'b1, 1'b0};
        int e, lat;
        for (int i = 0; i < 3; i++) begin
            evq.delete();
            send_frame(d[i], p[i], s[i], e);
            RxD = 1'b1;
            repeat (200) @(negedge clk);
            n_vec++;
            if (evq.size() != 1) begin
                n_err++; $display("FAIL directed_%0d_count got %0d want 1", i, evq.size());
            end else begin
                lat = evq[0].cyc - e;
                n_vec++;
                if (evq[0].f !== model(d[i], p[i], s[i])) begin
                    n_err++; $display("FAIL directed_%0d_pulse got %h want %h", i, evq[0].f, model(d[i], p[i], s[i]));
                end
                n_vec++;
                if (lat < LAT_MIN || lat > LAT_MAX) begin
                    n_err++; $display("FAIL directed_%0d_latency got %0d want %0d..%0d", i, lat, LAT_MIN, LAT_MAX);
                end
            end
            n_vec++;
            if (data_out !== d[i]) begin
                n_err++; $display("FAIL directed_%0d_hold got %h want %h", i, data_out, d[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0, e1;
        evq.delete();
        send_frame(8'hFF, 1'b0, 1'b1, e0);
        send_frame(8'h00, 1'b0, 1'b1, e1);
        RxD = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++;
        if (evq.size() != 2) begin
            n_err++; $display("FAIL b2b_count got %0d want 2", evq.size());
        end else begin
            n_vec++;
            if (evq[0].f !== model(8'hFF, 1'b0, 1'b1) || evq[1].f !== model(8'h00, 1'b0, 1'b1)) begin
                n_err++; $display("FAIL b2b_pulses got %h %h want %h %h", evq[0].f, evq[1].f,
                                  model(8'hFF, 1'b0, 1'b1), model(8'h00, 1'b0, 1'b1));
            end
            n_vec++;
            if (evq[1].cyc - evq[0].cyc != e1 - e0) begin
                n_err++; $display("FAIL b2b_spacing got %0d want %0d", evq[1].cyc - evq[0].cyc, e1 - e0);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] prev;
        prev = data_out;
        evq.delete();
        RxD = 1'b0;
        repeat (40) @(negedge clk);
        RxD = 1'b1;
        repeat (2000) @(negedge clk);
        n_vec++;
        if (evq.size() != 0 || data_out !== prev) begin
            n_err++; $display("FAIL glitch got %0d pulses data %h want 0 pulses data %h", evq.size(), data_out, prev);
        end
    endtask

    task automatic test_break();
        evq.delete();
        RxD = 1'b0;
        repeat (3000) @(negedge clk);
        n_vec++;
        if (evq.size() != 1) begin
            n_err++; $display("FAIL break_count got %0d want 1", evq.size());
        end else begin
            n_vec++;
            if (evq[0].f !== model(8'h00, 1'b0, 1'b0)) begin
                n_err++; $display("FAIL break_pulse got %h want %h", evq[0].f, model(8'h00, 1'b0, 1'b0));
            end
        end
        RxD = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, s;
        int e, lat;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 2) == 0);
            s = $urandom_range(0, 3) != 0;
            evq.delete();
            send_frame(d, p, s, e);
            RxD = 1'b1;
            repeat ($urandom_range(60, 400)) @(negedge clk);
            n_vec++;
            if (evq.size() != 1) begin
                n_err++; $display("FAIL random_%0d_count got %0d want 1", i, evq.size());
            end else begin
                lat = evq[0].cyc - e;
                n_vec++;
                if (evq[0].f !== model(d, p, s) || lat < LAT_MIN || lat > LAT_MAX) begin
                    n_err++; $display("FAIL random_%0d got %h lat %0d want %h lat %0d..%0d",
                                      i, evq[0].f, lat, model(d, p, s), LAT_MIN, LAT_MAX);
                end
            end
        end
    endtask

    task automatic test_enable_abort();
        logic [7:0]  prev;
        logic [10:0] bits;
        prev = data_out;
        bits = {1'b1, 1'b0, 8'h96, 1'b0};
        evq.delete();
        for (int i = 0; i < 5; i++) begin
            RxD = bits[i];
            repeat (BIT) @(negedge clk);
        end
        Rx_EN = 1'b0;
        RxD = 1'b1;
        repeat (100) @(negedge clk);
        Rx_EN = 1'b1;
        repeat (2000) @(negedge clk);
        n_vec++;
        if (evq.size() != 0 || data_out !== prev) begin
            n_err++; $display("FAIL enable_abort got %0d pulses data %h want 0 pulses data %h", evq.size(), data_out, prev);
        end
    endtask

    task automatic test_reset_midframe();
        int e;
        send_frame(8'h5A, 1'b0, 1'b1, e);
        RxD = 1'b1;
        repeat (200) @(negedge clk);
        n_vec++;
        if (data_out !== 8'h5A) begin
            n_err++; $display("FAIL premid_data got %h want 5a", data_out);
        end
        evq.delete();
        RxD = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({valid, PERROR, FERROR, data_out} !== 11'h000) begin
            n_err++; $display("FAIL reset_midframe got %h want 000", {valid, PERROR, FERROR, data_out});
        end
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2000) @(negedge clk);
        n_vec++;
        if (evq.size() != 0) begin
            n_err++; $display("FAIL reset_midframe_pulses got %0d want 0", evq.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_glitch();
        test_break();
        test_random();
        test_enable_abort();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
